// File: rtl/exc_unit.sv
// exc_unit: exception sequencer feeding the exception-side inputs of cp0.
// It turns exception requests, interrupts, ERET and reset into one-shot CP0
// updates, and produces a PC redirect and a pipeline flush.
// Optional build macro EXC_NMI_EN adds an nmi input that triggers a soft reset.
// All state advances only on clk edges where phi2=1.
// Handshake: no valid/ready. Every pulse output is registered, is high for
// exactly one phi2 period, and is zero otherwise. flush is held for the whole
// FLUSH interval. busy is high whenever the sequencer is not in IDLE.
module exc_unit #(
  parameter logic [63:0] RESET_VEC    = 64'hFFFFFFFFBFC00000,
  parameter logic [63:0] BEV_BASE     = 64'hFFFFFFFFBFC00200,
  parameter logic [63:0] NORM_BASE    = 64'hFFFFFFFF80000000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        phi2,
`ifdef EXC_NMI_EN
  input  logic        nmi,
`endif
  input  logic [31:0] exc_req,
  input  logic [63:0] exc_pc,
  input  logic        exc_bd,
  input  logic        eret_req,
  input  logic [31:0] cp0status,
  input  logic [31:0] cp0cause,
  input  logic [63:0] cp0epc,
  input  logic [63:0] cp0errorepc,
  output logic        cp0setexl,
  output logic [5:0]  cp0setexccode,
  output logic [65:0] cp0setepc,
  output logic        cp0coldreset,
  output logic        cp0softreset,
  output logic        cp0eret,
  output logic        redirect,
  output logic [63:0] redirect_pc,
  output logic        flush,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {S_COLD = 2'd0, S_IDLE = 2'd1, S_FLUSH = 2'd2} state_t;

  // Exception codes this core implements: 1-13, 15 and 23.
  localparam logic [31:0] IMPL_MASK = 32'h0080_BFFE;

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic        setexl_n, coldreset_n, softreset_n, eret_n, redirect_n, flush_n;
  logic [5:0]  setexccode_n;
  logic [65:0] setepc_n;
  logic [63:0] redirect_pc_n;

  logic        st_ie, st_exl, st_erl, st_bev;
  logic        exc_any, int_pend;
  logic [4:0]  exc_code;
  logic [63:0] vec_base, exc_vec, int_vec, epc_val;
  logic        unused_ok;

  assign st_ie   = cp0status[0];
  assign st_exl  = cp0status[1];
  assign st_erl  = cp0status[2];
  assign st_bev  = cp0status[22];
  assign exc_any = |(exc_req & IMPL_MASK);
  assign int_pend = st_ie && !st_exl && !st_erl && ((cp0cause[15:8] & cp0status[15:8]) != 8'd0);
  assign vec_base = st_bev ? BEV_BASE : NORM_BASE;
  // TLB refill (codes 2/3) uses offset 0 only when not already at exception level.
  assign exc_vec  = vec_base + ((((exc_code == 5'd2) || (exc_code == 5'd3)) && !st_exl) ? 64'h0 : 64'h180);
  assign int_vec  = vec_base + 64'h180;
  assign epc_val  = exc_bd ? (exc_pc - 64'd4) : exc_pc;
  assign state_dbg = state;
  assign unused_ok = &{1'b0, cp0status[31:23], cp0status[21:16], cp0status[7:3],
                       cp0cause[31:16], cp0cause[7:0]};

`ifdef EXC_NMI_EN
  logic nmi_q, nmi_pend, nmi_pend_n, nmi_rise;
  assign nmi_rise = nmi && !nmi_q;

  // NMI edge detector and pending latch, sampled on phi2 only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      nmi_q    <= 1'b0;
      nmi_pend <= 1'b0;
    end else if (phi2) begin
      nmi_q    <= nmi;
      nmi_pend <= nmi_pend_n;
    end
  end
`endif

  // Highest-priority implemented exception code among the requested bits.
  always_comb begin
    exc_code = 5'd0;
    if      (exc_req[4])  exc_code = 5'd4;
    else if (exc_req[6])  exc_code = 5'd6;
    else if (exc_req[2])  exc_code = 5'd2;
    else if (exc_req[11]) exc_code = 5'd11;
    else if (exc_req[10]) exc_code = 5'd10;
    else if (exc_req[8])  exc_code = 5'd8;
    else if (exc_req[9])  exc_code = 5'd9;
    else if (exc_req[13]) exc_code = 5'd13;
    else if (exc_req[12]) exc_code = 5'd12;
    else if (exc_req[15]) exc_code = 5'd15;
    else if (exc_req[5])  exc_code = 5'd5;
    else if (exc_req[3])  exc_code = 5'd3;
    else if (exc_req[1])  exc_code = 5'd1;
    else if (exc_req[7])  exc_code = 5'd7;
    else if (exc_req[23]) exc_code = 5'd23;
  end

  // Next-state and next-output logic; every output defaults to zero.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    setexl_n      = 1'b0;
    setexccode_n  = 6'd0;
    setepc_n      = 66'd0;
    coldreset_n   = 1'b0;
    softreset_n   = 1'b0;
    eret_n        = 1'b0;
    redirect_n    = 1'b0;
    redirect_pc_n = 64'd0;
    flush_n       = 1'b0;
`ifdef EXC_NMI_EN
    nmi_pend_n    = nmi_pend || nmi_rise;
`endif
    case (state)
      S_COLD: begin
        coldreset_n   = 1'b1;
        setepc_n      = {2'b00, exc_pc};
        redirect_n    = 1'b1;
        redirect_pc_n = RESET_VEC;
        flush_n       = 1'b1;
        cnt_n         = 3'd0;
        state_n       = S_FLUSH;
      end
      S_FLUSH: begin
        if (cnt == 3'(FLUSH_CYCLES)) begin
          state_n = S_IDLE;
        end else begin
          cnt_n   = cnt + 3'd1;
          flush_n = 1'b1;
        end
      end
      S_IDLE: begin
`ifdef EXC_NMI_EN
        if (nmi_rise || nmi_pend) begin
          nmi_pend_n    = 1'b0;
          softreset_n   = 1'b1;
          setepc_n      = {2'b00, exc_pc};
          redirect_n    = 1'b1;
          redirect_pc_n = RESET_VEC;
          flush_n       = 1'b1;
          cnt_n         = 3'd0;
          state_n       = S_FLUSH;
        end else
`endif
        if (exc_any) begin
          setexl_n      = 1'b1;
          setexccode_n  = {1'b1, exc_code};
          setepc_n      = st_exl ? 66'd0 : {1'b1, exc_bd, epc_val};
          redirect_n    = 1'b1;
          redirect_pc_n = exc_vec;
          flush_n       = 1'b1;
          cnt_n         = 3'd0;
          state_n       = S_FLUSH;
        end else if (eret_req) begin
          eret_n        = 1'b1;
          redirect_n    = 1'b1;
          redirect_pc_n = st_erl ? cp0errorepc : cp0epc;
          flush_n       = 1'b1;
          cnt_n         = 3'd0;
          state_n       = S_FLUSH;
        end else if (int_pend) begin
          setexl_n      = 1'b1;
          setexccode_n  = 6'b100000;
          setepc_n      = {1'b1, exc_bd, epc_val};
          redirect_n    = 1'b1;
          redirect_pc_n = int_vec;
          flush_n       = 1'b1;
          cnt_n         = 3'd0;
          state_n       = S_FLUSH;
        end
      end
      default: state_n = S_COLD;
    endcase
  end

  // State and registered outputs; asynchronous reset returns to COLD.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_COLD;
      cnt           <= 3'd0;
      cp0setexl     <= 1'b0;
      cp0setexccode <= 6'd0;
      cp0setepc     <= 66'd0;
      cp0coldreset  <= 1'b0;
      cp0softreset  <= 1'b0;
      cp0eret       <= 1'b0;
      redirect      <= 1'b0;
      redirect_pc   <= 64'd0;
      flush         <= 1'b0;
      busy          <= 1'b0;
    end else if (phi2) begin
      state         <= state_n;
      cnt           <= cnt_n;
      cp0setexl     <= setexl_n;
      cp0setexccode <= setexccode_n;
      cp0setepc     <= setepc_n;
      cp0coldreset  <= coldreset_n;
      cp0softreset  <= softreset_n;
      cp0eret       <= eret_n;
      redirect      <= redirect_n;
      redirect_pc   <= redirect_pc_n;
      flush         <= flush_n;
      busy          <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_exc_unit.sv
// Testbench for exc_unit: directed scenarios plus randomized trials checked
// against a priority-list reference model of the exception rules.
module tb_exc_unit;

  localparam logic [63:0] RESET_VEC = 64'hFFFFFFFFBFC00000;
  localparam logic [63:0] BEV_BASE  = 64'hFFFFFFFFBFC00200;
  localparam logic [63:0] NORM_BASE = 64'hFFFFFFFF80000000;
  localparam int          FC        = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        phi2 = 1'b0;
  logic        nmi = 1'b0;
  logic [31:0] exc_req = '0;
  logic [63:0] exc_pc = '0;
  logic        exc_bd = 1'b0;
  logic        eret_req = 1'b0;
  logic [31:0] cp0status = '0;
  logic [31:0] cp0cause = '0;
  logic [63:0] cp0epc = '0;
  logic [63:0] cp0errorepc = '0;
  logic        cp0setexl, cp0coldreset, cp0softreset, cp0eret, redirect, flush, busy;
  logic [5:0]  cp0setexccode;
  logic [65:0] cp0setepc;
  logic [63:0] redirect_pc;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  // Clock and phase: phi2 is high on every other rising clk edge.
  always #5 clk = ~clk;
  always @(negedge clk) phi2 = ~phi2;

  exc_unit dut (
    .clk(clk), .rstn(rstn), .phi2(phi2),
`ifdef EXC_NMI_EN
    .nmi(nmi),
`endif
    .exc_req(exc_req), .exc_pc(exc_pc), .exc_bd(exc_bd), .eret_req(eret_req),
    .cp0status(cp0status), .cp0cause(cp0cause), .cp0epc(cp0epc), .cp0errorepc(cp0errorepc),
    .cp0setexl(cp0setexl), .cp0setexccode(cp0setexccode), .cp0setepc(cp0setepc),
    .cp0coldreset(cp0coldreset), .cp0softreset(cp0softreset), .cp0eret(cp0eret),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush), .busy(busy),
    .state_dbg(state_dbg)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic        act;
    logic        setexl;
    logic [5:0]  exccode;
    logic [65:0] setepc;
    logic        eret;
    logic        redirect;
    logic [63:0] rpc;
  } exp_t;

  int prio_list [15] = '{4, 6, 2, 11, 10, 8, 9, 13, 12, 15, 5, 3, 1, 7, 23};
  int impl_list [15] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 15, 23};

  function automatic bit is_impl(input int c);
    for (int i = 0; i < 15; i++) if (impl_list[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t model(input logic [31:0] req, input logic er,
                                 input logic [31:0] st, input logic [31:0] ca,
                                 input logic [63:0] epc, input logic [63:0] eepc,
                                 input logic [63:0] pc, input logic bd);
    exp_t e;
    int   code;
    bit   found;
    logic [63:0] base;
    logic [63:0] saved;
    e = '{act: 1'b0, setexl: 1'b0, exccode: 6'd0, setepc: 66'd0,
          eret: 1'b0, redirect: 1'b0, rpc: 64'd0};
    found = 1'b0;
    code = 0;
    for (int i = 0; i < 15; i++) begin
      if (!found && req[prio_list[i]] && is_impl(prio_list[i])) begin
        found = 1'b1;
        code = prio_list[i];
      end
    end
    base  = st[22] ? BEV_BASE : NORM_BASE;
    saved = bd ? pc - 64'd4 : pc;
    if (found) begin
      e.act = 1'b1; e.setexl = 1'b1; e.redirect = 1'b1;
      e.exccode = {1'b1, 5'(code)};
      e.setepc = st[1] ? 66'd0 : {1'b1, bd, saved};
      e.rpc = base + (((code == 2 || code == 3) && !st[1]) ? 64'h0 : 64'h180);
    end else if (er) begin
      e.act = 1'b1; e.eret = 1'b1; e.redirect = 1'b1;
      e.rpc = st[2] ? eepc : epc;
    end else if (st[0] && !st[1] && !st[2] && ((ca[15:8] & st[15:8]) != 0)) begin
      e.act = 1'b1; e.setexl = 1'b1; e.redirect = 1'b1;
      e.exccode = 6'b100000;
      e.setepc = {1'b1, bd, saved};
      e.rpc = base + 64'h180;
    end
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  // Advance to just after the next phi2-qualified rising clk edge.
  task automatic step;
    @(posedge clk);
    while (!phi2) @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    exc_req = '0; eret_req = 1'b0; cp0cause = '0; exc_bd = 1'b0;
  endtask

  // Ride out the flush interval after a take.
  task automatic settle;
    repeat (FC + 1) step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int n;
    rstn = 1'b0;
    clear_inputs();
    cp0status = '0;
    exc_pc = 64'h0000_0000_1234_5678;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({cp0setexl, cp0coldreset, cp0eret, redirect, flush, busy} !== 6'b0)
      begin errors++; $display("FAIL reset_outs got=%b want=000000", {cp0setexl, cp0coldreset, cp0eret, redirect, flush, busy}); end
    checks++; if (redirect_pc !== 64'd0 || cp0setepc !== 66'd0)
      begin errors++; $display("FAIL reset_vals got pc=%h epc=%h want 0", redirect_pc, cp0setepc); end
    rstn = 1'b1;
    step();
    checks++; if (cp0coldreset !== 1'b1 || redirect !== 1'b1)
      begin errors++; $display("FAIL cold_pulse got cr=%b rd=%b want 1 1", cp0coldreset, redirect); end
    checks++; if (redirect_pc !== RESET_VEC)
      begin errors++; $display("FAIL cold_vec got=%h want=%h", redirect_pc, RESET_VEC); end
    checks++; if (cp0setepc !== {2'b00, exc_pc})
      begin errors++; $display("FAIL cold_epc got=%h want=%h", cp0setepc, {2'b00, exc_pc}); end
    checks++; if (cp0softreset !== 1'b0)
      begin errors++; $display("FAIL cold_soft got=%b want=0", cp0softreset); end
    // A non-phi2 clk edge must not end the pulse.
    @(posedge clk); #1;
    checks++; if (cp0coldreset !== 1'b1)
      begin errors++; $display("FAIL cold_hold got=%b want=1", cp0coldreset); end
    n = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) begin
        checks++; if (cp0coldreset !== 1'b0 || redirect !== 1'b0)
          begin errors++; $display("FAIL cold_end got cr=%b rd=%b want 0 0", cp0coldreset, redirect); end
      end
      if (!flush) break;
      n++;
    end
    checks++; if (n != FC + 1)
      begin errors++; $display("FAIL cold_flush_len got=%0d want=%0d", n, FC + 1); end
    checks++; if (busy !== 1'b0)
      begin errors++; $display("FAIL cold_idle busy got=%b want=0", busy); end
  endtask

  task automatic test_priority;
    cp0status = '0;
    exc_req = (32'd1 << 12) | (32'd1 << 8);
    exc_pc = 64'hFFFFFFFF80001000;
    exc_bd = 1'b0;
    step();
    checks++; if (cp0setexccode !== 6'h28)
      begin errors++; $display("FAIL prio_code got=%h want=28", cp0setexccode); end
    checks++; if (cp0setepc !== {1'b1, 1'b0, 64'hFFFFFFFF80001000})
      begin errors++; $display("FAIL prio_epc got=%h", cp0setepc); end
    checks++; if (redirect_pc !== 64'hFFFFFFFF80000180 || cp0setexl !== 1'b1 || flush !== 1'b1)
      begin errors++; $display("FAIL prio_vec got=%h exl=%b fl=%b", redirect_pc, cp0setexl, flush); end
    clear_inputs();
    settle();
    checks++; if (busy !== 1'b0)
      begin errors++; $display("FAIL prio_idle busy got=%b want=0", busy); end
  endtask

  task automatic test_bd_exl;
    // EXL already set: EPC not written, general vector even for TLB refill.
    cp0status = 32'h0000_0002;
    exc_req = 32'd1 << 2;
    exc_bd = 1'b1;
    exc_pc = 64'hFFFFFFFF80002000;
    step();
    checks++; if (cp0setepc[65] !== 1'b0)
      begin errors++; $display("FAIL bdexl_epcvalid got=%b want=0", cp0setepc[65]); end
    checks++; if (redirect_pc !== 64'hFFFFFFFF80000180 || cp0setexccode !== 6'h22)
      begin errors++; $display("FAIL bdexl_vec got=%h code=%h want ffffffff80000180 22", redirect_pc, cp0setexccode); end
    clear_inputs();
    settle();
    // EXL clear, BEV set, PC 0 in a delay slot: refill vector and wrapped EPC.
    cp0status = 32'h0040_0000;
    exc_req = 32'd1 << 3;
    exc_bd = 1'b1;
    exc_pc = 64'd0;
    step();
    checks++; if (cp0setepc !== {1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFC})
      begin errors++; $display("FAIL bd_wrap got=%h", cp0setepc); end
    checks++; if (redirect_pc !== BEV_BASE)
      begin errors++; $display("FAIL bev_refill got=%h want=%h", redirect_pc, BEV_BASE); end
    clear_inputs();
    settle();
  endtask

  task automatic test_interrupt;
    cp0status = 32'h0000_8001;
    cp0cause = 32'h0000_8000;
    exc_pc = 64'hFFFFFFFF80003000;
    step();
    checks++; if (cp0setexccode !== 6'h20 || cp0setexl !== 1'b1)
      begin errors++; $display("FAIL int_code got=%h exl=%b want 20 1", cp0setexccode, cp0setexl); end
    checks++; if (redirect_pc !== 64'hFFFFFFFF80000180 || cp0setepc !== {2'b10, 64'hFFFFFFFF80003000})
      begin errors++; $display("FAIL int_vec got=%h epc=%h", redirect_pc, cp0setepc); end
    clear_inputs();
    settle();
    cp0status = 32'h0000_8003;
    cp0cause = 32'h0000_8000;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (busy !== 1'b0 || redirect !== 1'b0)
        begin errors++; $display("FAIL int_masked busy=%b rd=%b want 0 0", busy, redirect); end
    end
    clear_inputs();
  endtask

  task automatic test_eret;
    cp0status = 32'h0000_0004;
    cp0errorepc = 64'h00000000BFC00400;
    cp0epc = 64'h0000_0000_0000_1110;
    eret_req = 1'b1;
    step();
    checks++; if (cp0eret !== 1'b1 || redirect !== 1'b1 || cp0setexl !== 1'b0)
      begin errors++; $display("FAIL eret_pulse got er=%b rd=%b exl=%b want 1 1 0", cp0eret, redirect, cp0setexl); end
    checks++; if (redirect_pc !== 64'h00000000BFC00400)
      begin errors++; $display("FAIL eret_pc got=%h want=00000000bfc00400", redirect_pc); end
    clear_inputs();
    settle();
    eret_req = 1'b1;
    exc_req = 32'd1 << 10;
    step();
    checks++; if (cp0eret !== 1'b0 || cp0setexccode !== 6'h2A || cp0setexl !== 1'b1)
      begin errors++; $display("FAIL eret_preempt got er=%b code=%h exl=%b", cp0eret, cp0setexccode, cp0setexl); end
    clear_inputs();
    settle();
  endtask

  task automatic test_async_reset;
    cp0status = '0;
    exc_req = 32'd1 << 4;
    step();
    clear_inputs();
    step();
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    checks++; if ({flush, busy, redirect, cp0setexl, cp0eret, cp0coldreset} !== 6'b0 || cp0setexccode !== 6'd0)
      begin errors++; $display("FAIL areset_outs got=%b code=%h want zeros", {flush, busy, redirect, cp0setexl, cp0eret, cp0coldreset}, cp0setexccode); end
    #3;
    rstn = 1'b1;
    step();
    checks++; if (cp0coldreset !== 1'b1 || flush !== 1'b1 || redirect_pc !== RESET_VEC)
      begin errors++; $display("FAIL areset_cold got cr=%b fl=%b pc=%h", cp0coldreset, flush, redirect_pc); end
    settle();
    checks++; if (busy !== 1'b0)
      begin errors++; $display("FAIL areset_idle busy got=%b want=0", busy); end
  endtask

  task automatic test_random;
    exp_t e;
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 3))
        0: exc_req = '0;
        1: exc_req = 32'd1 << $urandom_range(0, 31);
        default: exc_req = $urandom & $urandom & $urandom;
      endcase
      eret_req    = 1'($urandom_range(0, 1));
      cp0status   = $urandom;
      cp0cause    = $urandom;
      exc_pc      = {$urandom, $urandom};
      exc_bd      = 1'($urandom_range(0, 1));
      cp0epc      = {$urandom, $urandom};
      cp0errorepc = {$urandom, $urandom};
      e = model(exc_req, eret_req, cp0status, cp0cause, cp0epc, cp0errorepc, exc_pc, exc_bd);
      step();
      checks++; if (cp0setexl !== e.setexl || cp0setexccode !== e.exccode || cp0eret !== e.eret || redirect !== e.redirect)
        begin errors++; $display("FAIL rand_ctl t=%0d got exl=%b code=%h er=%b rd=%b want %b %h %b %b",
          t, cp0setexl, cp0setexccode, cp0eret, redirect, e.setexl, e.exccode, e.eret, e.redirect); end
      if (e.redirect) begin
        checks++; if (redirect_pc !== e.rpc)
          begin errors++; $display("FAIL rand_pc t=%0d got=%h want=%h", t, redirect_pc, e.rpc); end
      end
      checks++; if (cp0setepc[65] !== e.setepc[65] || (e.setepc[65] && cp0setepc !== e.setepc))
        begin errors++; $display("FAIL rand_epc t=%0d got=%h want=%h", t, cp0setepc, e.setepc); end
      clear_inputs();
      if (e.act) settle();
      checks++; if (busy !== 1'b0 || cp0coldreset !== 1'b0)
        begin errors++; $display("FAIL rand_idle t=%0d busy=%b cr=%b want 0 0", t, busy, cp0coldreset); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_priority();
    test_bd_exl();
    test_interrupt();
    test_eret();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
